// File: rtl/subtrator_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and counter sizing.
package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Request/result bundle between the lab datapath and the serial subtractor.
interface subtrator_serial_if #(parameter int WIDTH = 4);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diferenca;
    logic             borrow;
    logic             zero;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diferenca, borrow, zero, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diferenca, borrow, zero, overflow
    );

endinterface

// File: rtl/subtrator_1bit.sv
// Combinational full subtractor: d = x - y - bin, with borrow out.
module subtrator_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell plus a borrow FF.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    subtrator_serial_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, rr;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             a_msb, b_msb;
    logic             d_i, bw_nxt;
    logic             last;
    logic [WIDTH-1:0] res_nxt;

    logic [WIDTH-1:0] dif_q;
    logic             borrow_q, zero_q, overflow_q;

    subtrator_1bit u_cell (
        .x   (ra[0]),
        .y   (rb[0]),
        .bin (bw),
        .d   (d_i),
        .bout(bw_nxt)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    assign res_nxt = {d_i, rr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN) || (state == DONE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra         <= '0;
            rb         <= '0;
            rr         <= '0;
            cnt        <= '0;
            bw         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            dif_q      <= '0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    ra    <= bus.a;
                    rb    <= bus.b;
                    bw    <= 1'b0;
                    cnt   <= '0;
                    a_msb <= bus.a[WIDTH-1];
                    b_msb <= bus.b[WIDTH-1];
                end
                RUN: begin
                    rr  <= res_nxt;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    bw  <= bw_nxt;
                    cnt <= cnt + 1'b1;
                    // Final bit is d_i, so flags are taken from res_nxt rather than rr.
                    if (last) begin
                        dif_q      <= res_nxt;
                        borrow_q   <= bw_nxt;
                        zero_q     <= ~|res_nxt;
                        overflow_q <= (a_msb != b_msb) && (d_i != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diferenca = dif_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;

endmodule
